// File: rtl/fir_output_monitor_if.sv
// Sample stream in and frame statistics out for the FIR output monitor.
// master: the side that produces FIR samples and reads the statistics.
// slave : the monitor itself.
interface fir_output_monitor_if #(
    parameter int unsigned ACC_W = 24
);
    logic                en;
    logic signed [15:0]  Yn;
    logic                frame_valid;
    logic signed [15:0]  y_max;
    logic signed [15:0]  y_min;
    logic [ACC_W-1:0]    abs_sum;
    logic [7:0]          zero_cross;
    logic [15:0]         frame_cnt;
    logic                filling;

    modport master (
        output en, Yn,
        input  frame_valid, y_max, y_min, abs_sum, zero_cross, frame_cnt, filling
    );

    modport slave (
        input  en, Yn,
        output frame_valid, y_max, y_min, abs_sum, zero_cross, frame_cnt, filling
    );
endinterface

// File: rtl/fir_output_monitor.sv
// Reduces the signed 16-bit FIR output stream to per-frame max, min,
// sum of absolute values and zero-crossing count. After reset the first
// LATENCY accepted samples (pipeline fill) are dropped.
module fir_output_monitor #(
    parameter int unsigned FRAME_LEN = 177,
    parameter int unsigned LATENCY   = 8,
    parameter int unsigned ACC_W     = 24
) (
    input  logic                 clk,
    input  logic                 RstN,
    fir_output_monitor_if.slave  mon
);

    localparam int unsigned FILL_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned FILL_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned IDX_LAST  = FRAME_LEN - 1;

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    localparam state_t ST_RESET = (LATENCY > 0) ? S_FILL : S_RUN;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_filling;

    logic [FILL_W-1:0]   r_fill_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic signed [15:0]  r_run_max;
    logic signed [15:0]  r_run_min;
    logic [ACC_W-1:0]    r_run_sum;
    logic [7:0]          r_run_zc;
    logic                r_prev_sign;

    logic                r_frame_valid;
    logic signed [15:0]  r_y_max;
    logic signed [15:0]  r_y_min;
    logic [ACC_W-1:0]    r_abs_sum;
    logic [7:0]          r_zero_cross;
    logic [15:0]         r_frame_cnt;

    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic [16:0]         w_yn_ext;
    logic [16:0]         w_abs;
    logic signed [15:0]  w_max_nxt;
    logic signed [15:0]  w_min_nxt;
    logic [ACC_W-1:0]    w_sum_nxt;
    logic [7:0]          w_zc_nxt;

    // State register
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave FILL on the accepted sample that completes the fill
    always_comb begin
        w_state_nxt = r_state;
        w_filling   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_filling = 1'b1;
                if (mon.en && (r_fill_cnt == FILL_W'(FILL_LAST))) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // Per-sample statistic updates; 17-bit magnitude keeps |-32768| exact
    always_comb begin
        w_accept  = mon.en && (r_state == S_RUN);
        w_first   = (r_idx == '0);
        w_last    = w_accept && (r_idx == IDX_W'(IDX_LAST));
        w_yn_ext  = {mon.Yn[15], mon.Yn};
        w_abs     = mon.Yn[15] ? (17'd0 - w_yn_ext) : w_yn_ext;
        w_max_nxt = (w_first || ($signed(mon.Yn) > $signed(r_run_max))) ? mon.Yn : r_run_max;
        w_min_nxt = (w_first || ($signed(mon.Yn) < $signed(r_run_min))) ? mon.Yn : r_run_min;
        w_sum_nxt = (w_first ? '0 : r_run_sum) + ACC_W'(w_abs);
        w_zc_nxt  = w_first ? '0 : r_run_zc + {7'd0, (mon.Yn[15] != r_prev_sign)};
    end

    // Fill counter, running accumulators and frame-close result registers
    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_fill_cnt    <= '0;
            r_idx         <= '0;
            r_run_max     <= '0;
            r_run_min     <= '0;
            r_run_sum     <= '0;
            r_run_zc      <= '0;
            r_prev_sign   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_y_max       <= '0;
            r_y_min       <= '0;
            r_abs_sum     <= '0;
            r_zero_cross  <= '0;
            r_frame_cnt   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            if ((r_state == S_FILL) && mon.en) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (w_accept) begin
                r_run_max   <= w_max_nxt;
                r_run_min   <= w_min_nxt;
                r_run_sum   <= w_sum_nxt;
                r_run_zc    <= w_zc_nxt;
                r_prev_sign <= mon.Yn[15];
                r_idx       <= w_last ? '0 : r_idx + 1'b1;
            end
            if (w_last) begin
                r_frame_valid <= 1'b1;
                r_y_max       <= w_max_nxt;
                r_y_min       <= w_min_nxt;
                r_abs_sum     <= w_sum_nxt;
                r_zero_cross  <= w_zc_nxt;
                r_frame_cnt   <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign mon.frame_valid = r_frame_valid;
    assign mon.y_max       = r_y_max;
    assign mon.y_min       = r_y_min;
    assign mon.abs_sum     = r_abs_sum;
    assign mon.zero_cross  = r_zero_cross;
    assign mon.frame_cnt   = r_frame_cnt;
    assign mon.filling     = w_filling;

endmodule

// File: tb/tb_fir_output_monitor.sv
// Directed bench for fir_output_monitor: a short-frame instance
// (FRAME_LEN=4, LATENCY=2) and a full-length instance (177, no fill).
module tb_fir_output_monitor;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_a = 0;
    int pulse_b = 0;
    int pulse_cyc_a = 0;

    fir_output_monitor_if #(.ACC_W(24)) ifa ();
    fir_output_monitor_if #(.ACC_W(24)) ifb ();

    fir_output_monitor #(.FRAME_LEN(4), .LATENCY(2), .ACC_W(24)) u_a (
        .clk  (clk),
        .RstN (rst_a),
        .mon  (ifa)
    );

    fir_output_monitor #(.FRAME_LEN(177), .LATENCY(0), .ACC_W(24)) u_b (
        .clk  (clk),
        .RstN (rst_b),
        .mon  (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ifa.frame_valid === 1'b1) begin
            pulse_a++;
            pulse_cyc_a = cyc;
        end
        if (ifb.frame_valid === 1'b1) pulse_b++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int mx, input int mn,
                           input int sum, input int zc, input int cnt);
        check({tag, "_max"}, 32'($signed(ifa.y_max)), mx);
        check({tag, "_min"}, 32'($signed(ifa.y_min)), mn);
        check({tag, "_sum"}, 32'(ifa.abs_sum), sum);
        check({tag, "_zc"},  32'(ifa.zero_cross), zc);
        check({tag, "_cnt"}, 32'(ifa.frame_cnt), cnt);
    endtask

    // One accepting cycle, then `gap` idle cycles carrying junk on Yn.
    // Called and returns at a falling edge.
    task automatic send_a(input int v, input int gap);
        ifa.en = 1'b1;
        ifa.Yn = 16'(v);
        @(negedge clk);
        for (int i = 0; i < gap; i++) begin
            ifa.en = 1'b0;
            ifa.Yn = 16'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_b(input int v);
        ifb.en = 1'b1;
        ifb.Yn = 16'(v);
        @(negedge clk);
    endtask

    task automatic scen1_stream(input string tag, input int gap);
        send_a(5, gap);
        if (gap == 0) check({tag, "_fill1"}, 32'(ifa.filling), 1);
        send_a(5, gap);
        check({tag, "_fill2"}, 32'(ifa.filling), 0);
        send_a(10, gap);
        send_a(-20, gap);
        send_a(30, gap);
        check({tag, "_fv_pre"}, 32'(ifa.frame_valid), 0);
        send_a(-40, 0);
        check({tag, "_fv"}, 32'(ifa.frame_valid), 1);
    endtask

    int p0;
    int t1;

    initial begin
        ifa.en = 1'b0; ifa.Yn = '0;
        ifb.en = 1'b0; ifb.Yn = '0;
        rst_a = 1'b0;  rst_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_fv", 32'(ifa.frame_valid), 0);
        check_a("rst", 0, 0, 0, 0, 0);
        check("rst_fill_a", 32'(ifa.filling), 1);
        check("rst_fill_b", 32'(ifb.filling), 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Scenario 1
        p0 = pulse_a;
        scen1_stream("s1", 0);
        check_a("s1", 30, -40, 100, 3, 1);

        // Scenario 2: back-to-back frame
        send_a(1, 0);
        check("s2_fv_drop", 32'(ifa.frame_valid), 0);
        check("s1_pulses", pulse_a - p0, 1);
        t1 = pulse_cyc_a;
        send_a(2, 0);
        check("s2_hold_max", 32'($signed(ifa.y_max)), 30);
        send_a(3, 0);
        send_a(4, 0);
        check("s2_fv", 32'(ifa.frame_valid), 1);
        check_a("s2", 4, 1, 10, 0, 2);

        // Scenario 3: most negative value
        send_a(-32768, 0);
        check("s2_spacing", pulse_cyc_a - t1, 4);
        send_a(-32768, 0);
        send_a(-32768, 0);
        send_a(-32768, 0);
        check_a("s3", -32768, -32768, 131072, 0, 3);
        ifa.en = 1'b0;
        @(negedge clk);
        check("s3_fv_drop", 32'(ifa.frame_valid), 0);

        // Scenario 4: scenario 1 again from reset, 3 idle cycles between samples
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        p0 = pulse_a;
        scen1_stream("s4", 3);
        check_a("s4", 30, -40, 100, 3, 1);
        repeat (3) begin
            ifa.en = 1'b0;
            ifa.Yn = 16'($urandom);
            @(negedge clk);
        end
        check("s4_hold_max", 32'($signed(ifa.y_max)), 30);
        check("s4_hold_zc", 32'(ifa.zero_cross), 3);
        check("s4_pulses", pulse_a - p0, 1);

        // Scenario 5: reset during a partial frame
        send_a(5, 0);
        send_a(5, 0);
        send_a(10, 0);
        send_a(-20, 0);
        ifa.en = 1'b0;
        rst_a = 1'b0;
        #1;
        check_a("s5_rst", 0, 0, 0, 0, 0);
        check("s5_rst_fill", 32'(ifa.filling), 1);
        @(negedge clk);
        rst_a = 1'b1;
        p0 = pulse_a;
        scen1_stream("s5", 0);
        check_a("s5", 30, -40, 100, 3, 1);
        ifa.en = 1'b0;
        @(negedge clk);
        check("s5_pulses", pulse_a - p0, 1);

        // Scenario 6: full-length frame, no fill, alternating +/-100
        check("s6_fill", 32'(ifb.filling), 0);
        for (int i = 0; i < 177; i++) begin
            if (i == 176) check("s6_fv_pre", 32'(ifb.frame_valid), 0);
            send_b((i % 2 == 0) ? 100 : -100);
        end
        check("s6_fv", 32'(ifb.frame_valid), 1);
        check("s6_max", 32'($signed(ifb.y_max)), 100);
        check("s6_min", 32'($signed(ifb.y_min)), -100);
        check("s6_sum", 32'(ifb.abs_sum), 17700);
        check("s6_zc", 32'(ifb.zero_cross), 176);
        check("s6_cnt", 32'(ifb.frame_cnt), 1);
        ifb.en = 1'b0;
        @(negedge clk);
        check("s6_pulses", pulse_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
